// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and owner constants for the unified memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;
endpackage

// File: rtl/mem_arb_latency_counter.sv
// mem_arb_latency_counter: counts the fixed memory latency down from issue to capture
module mem_arb_latency_counter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LATENCY - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // load on grant, count down while waiting, hold at zero
  always_comb cnt_d = load ? LOAD_VAL : (dec && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign zero = cnt_q == '0;
endmodule

// File: rtl/unified_memory_arbiter.sv
// unified_memory_arbiter: round-robin sharing of one fixed-latency memory between fetch and data ports
module unified_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [DATA_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  pipe_stall
);
  state_e state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, we_q, we_d;
  logic if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic winner, grant, done, zero;
  mem_arb_latency_counter #(.MEM_LATENCY(MEM_LATENCY)) u_cnt (
    .clk(clk),
    .reset(reset),
    .load(grant),
    .dec(state_q == WAIT),
    .zero(zero)
  );
  // grant/issue in IDLE, count down in WAIT, pulse ready in RESP
  always_comb begin
    winner = (if_req && dm_req) ? ~last_q : (dm_req ? OWN_DM : OWN_IF);
    grant = state_q == IDLE && !reset && (if_req || dm_req);
    done = state_q == WAIT && zero;
    state_d = state_q == IDLE ? (grant ? WAIT : IDLE) : state_q == WAIT ? (zero ? RESP : WAIT) : IDLE;
    owner_d = grant ? winner : owner_q;
    last_d = grant ? winner : last_q;
    we_d = grant ? (winner == OWN_DM) && dm_we : we_q;
    if_ready_d = done && owner_q == OWN_IF;
    dm_ready_d = done && owner_q == OWN_DM;
    if_rdata_d = if_ready_d ? mem_rdata : if_rdata_q;
    dm_rdata_d = (dm_ready_d && !we_q) ? mem_rdata : dm_rdata_q;
    mem_en = grant;
    mem_we = grant && winner == OWN_DM && dm_we;
    mem_addr = !grant ? '0 : (winner == OWN_DM ? dm_addr : if_addr);
    mem_wdata = (grant && winner == OWN_DM) ? dm_wdata : '0;
  end
  // state, ownership and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      last_q <= OWN_IF;
      we_q <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      we_q <= we_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end
  assign if_ready = if_ready_q;
  assign dm_ready = dm_ready_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign pipe_stall = (if_req && !if_ready_q) || (dm_req && !dm_ready_q);
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// tb_unified_memory_arbiter: transaction-level model plus directed checks for the memory arbiter
module tb_unified_memory_arbiter;
  localparam int L = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_ready, dm_ready, mem_en, mem_we, pipe_stall;
  logic if_req1 = 0, dm_req1 = 0, dm_we1 = 0;
  logic [31:0] if_addr1 = 0, dm_addr1 = 0, dm_wdata1 = 0, mem_rdata1 = 32'hFFFF_FFFF;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic if_ready1, dm_ready1, mem_en1, mem_we1, pipe_stall1;
  unified_memory_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
  );
  unified_memory_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
    .if_ready(if_ready1), .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_ready(dm_ready1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .pipe_stall(pipe_stall1)
  );
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0, cyc = 0, resp_t = -1;
  logic [31:0] resp_v = 0;
  logic [31:0] mem_arr [logic [31:0]];
  bit m_busy = 0, m_own = 0, m_we = 0, m_last = 0;
  int m_issue = 0;
  logic [31:0] m_val = 0, m_if_rdata = 0, m_dm_rdata = 0;
  logic s_mem_en, s_mem_we, s_if_ready, s_dm_ready, s_stall, s1_mem_en, s1_dm_ready;
  logic [31:0] s_mem_addr, s_mem_wdata, s_if_rdata, s_dm_rdata, s1_mem_addr, s1_dm_rdata;
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : a ^ 32'hC0DE_0000;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic tick();
    bit g, own, eif, edm;
    logic [31:0] ea;
    @(negedge clk);
    g = !m_busy && !reset && (if_req || dm_req);
    own = (if_req && dm_req) ? !m_last : dm_req;
    ea = !g ? 32'h0 : (own ? dm_addr : if_addr);
    eif = m_busy && !m_own && cyc == m_issue + L + 1;
    edm = m_busy && m_own && cyc == m_issue + L + 1;
    s_mem_en = mem_en; s_mem_we = mem_we; s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;
    s_if_ready = if_ready; s_if_rdata = if_rdata; s_dm_ready = dm_ready; s_dm_rdata = dm_rdata;
    s_stall = pipe_stall;
    s1_mem_en = mem_en1; s1_mem_addr = mem_addr1; s1_dm_ready = dm_ready1; s1_dm_rdata = dm_rdata1;
    chk("mdl_mem_en", mem_en, g);
    chk("mdl_mem_we", mem_we, g && own && dm_we);
    chk("mdl_mem_addr", mem_addr, ea);
    if (!g || (own && dm_we)) chk("mdl_mem_wdata", mem_wdata, g ? dm_wdata : 32'h0);
    chk("mdl_if_ready", if_ready, eif);
    chk("mdl_dm_ready", dm_ready, edm);
    chk("mdl_if_rdata", if_rdata, m_if_rdata);
    chk("mdl_dm_rdata", dm_rdata, m_dm_rdata);
    chk("mdl_stall", pipe_stall, (if_req && !eif) || (dm_req && !edm));
    if (g) m_val = mem_rd(ea);
    if (mem_en === 1'b1) begin
      if (mem_we) mem_arr[mem_addr] = mem_wdata;
      else begin
        resp_t = cyc + L;
        resp_v = mem_rd(mem_addr);
      end
    end
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_last = 0; m_if_rdata = 0; m_dm_rdata = 0;
    end else if (m_busy) begin
      if (cyc == m_issue + L && !m_we) begin
        if (m_own) m_dm_rdata = m_val;
        else m_if_rdata = m_val;
      end
      if (cyc == m_issue + L + 1) m_busy = 0;
    end else if (g) begin
      m_busy = 1; m_own = own; m_we = own && dm_we; m_issue = cyc; m_last = own;
    end
    cyc++;
    #1;
    mem_rdata = (cyc == resp_t) ? resp_v : (32'hBAD0_0000 ^ 32'(cyc));
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask
  initial begin
    int n_en;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_if_rdata", s_if_rdata, 0);
    chk("rst_dm_ready", s_dm_ready, 0);
    mem_arr[32'h0040_0000] = 32'h2008_0005;
    if_req = 1; if_addr = 32'h0040_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_stall", s_stall, i < 3);
      if (i == 0) begin
        chk("t1_en0", s_mem_en, 1);
        chk("t1_addr0", s_mem_addr, 32'h0040_0000);
      end else chk("t1_en", s_mem_en, 0);
    end
    chk("t1_ready3", s_if_ready, 1);
    chk("t1_rdata3", s_if_rdata, 32'h2008_0005);
    if_req = 0;
    tick();
    do_reset();
    if_req = 1; if_addr = 32'h0040_0004; dm_req = 1; dm_we = 0; dm_addr = 32'h1001_0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 7) chk("t2_stall", s_stall, 1);
      if (i == 0) begin
        chk("t2_en0", s_mem_en, 1);
        chk("t2_addr0", s_mem_addr, 32'h1001_0000);
      end
      if (i == 3) begin
        chk("t2_dm_ready3", s_dm_ready, 1);
        dm_req = 0;
      end
      if (i == 4) begin
        chk("t2_en4", s_mem_en, 1);
        chk("t2_addr4", s_mem_addr, 32'h0040_0004);
      end
    end
    chk("t2_if_ready7", s_if_ready, 1);
    if_req = 0;
    tick();
    do_reset();
    mem_arr[32'h1001_0008] = 32'h0000_0007;
    dm_req = 1; dm_we = 0; dm_addr = 32'h1001_0008;
    repeat (4) tick();
    chk("t3_load", s_dm_rdata, 32'h0000_0007);
    dm_req = 0;
    tick();
    dm_req = 1; dm_we = 1; dm_addr = 32'h1001_0000; dm_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        chk("t3_en", s_mem_en, 1);
        chk("t3_we", s_mem_we, 1);
        chk("t3_addr", s_mem_addr, 32'h1001_0000);
        chk("t3_wdata", s_mem_wdata, 32'hDEAD_BEEF);
      end else chk("t3_en_off", s_mem_en, 0);
    end
    chk("t3_ready3", s_dm_ready, 1);
    chk("t3_rdata_kept", s_dm_rdata, 32'h0000_0007);
    dm_req = 0; dm_we = 0;
    tick();
    chk("t3_rdata_after", s_dm_rdata, 32'h0000_0007);
    chk("t3_mem_written", mem_rd(32'h1001_0000), 32'hDEAD_BEEF);
    do_reset();
    if_req = 1; if_addr = 32'h0040_0008; dm_req = 1; dm_addr = 32'h1001_0010;
    n_en = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (s_mem_en === 1'b1) n_en++;
      if (i % 4 == 0) begin
        chk("t4_en", s_mem_en, 1);
        chk("t4_addr", s_mem_addr, (i % 8 == 0) ? 32'h1001_0010 : 32'h0040_0008);
      end
    end
    chk("t4_issue_count", n_en, 4);
    if_req = 0; dm_req = 0;
    tick();
    do_reset();
    if_req = 1; if_addr = 32'h0040_0000;
    tick();
    chk("t5_en0", s_mem_en, 1);
    reset = 1;
    tick();
    chk("t5_en1", s_mem_en, 0);
    reset = 0;
    for (int i = 2; i < 6; i++) begin
      tick();
      chk("t5_ready", s_if_ready, i == 5);
      if (i == 2) begin
        chk("t5_rdata2", s_if_rdata, 0);
        chk("t5_reissue", s_mem_en, 1);
      end
    end
    chk("t5_rdata5", s_if_rdata, 32'h2008_0005);
    if_req = 0;
    tick();
    do_reset();
    dm_req1 = 1; dm_addr1 = 32'h1001_0004;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_rdata1 = (i == 0) ? 32'h0000_00AB : 32'hFFFF_FFFF;
      if (i == 0) begin
        chk("t6_en0", s1_mem_en, 1);
        chk("t6_addr0", s1_mem_addr, 32'h1001_0004);
      end
      if (i == 1) begin
        chk("t6_en1", s1_mem_en, 0);
        chk("t6_ready1", s1_dm_ready, 0);
      end
      if (i == 2) begin
        chk("t6_ready2", s1_dm_ready, 1);
        chk("t6_rdata2", s1_dm_rdata, 32'h0000_00AB);
      end
      if (i == 3) chk("t6_regrant3", s1_mem_en, 1);
    end
    dm_req1 = 0;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
